// File: rtl/rom_boot_copier.sv
// Copies COPY_WORDS words from a synchronous-read boot ROM to memory at DEST_BASE using Wishbone classic writes.
// Each word takes at least three cycles: fetch, capture, write. Every output comes from a register.
module rom_boot_copier #(
  parameter int          ROM_SIZE      = 256*4,
  parameter int          COPY_WORDS    = ROM_SIZE/4,
  parameter logic [31:0] DEST_BASE     = 32'h0000_0000,
  parameter int          ACK_TIMEOUT   = 255,
  localparam int         ROM_ADDR_BITS = $clog2(ROM_SIZE/4)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  output logic                     rom_ce,
  input  logic [31:0]              rom_data,
  output logic [31:0]              wb_adr_o,
  output logic [31:0]              wb_dat_o,
  output logic [3:0]               wb_sel_o,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  input  logic                     wb_ack_i,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  // One extra index bit lets a full-ROM copy reach its last word without wrapping.
  localparam int IW = ROM_ADDR_BITS + 1;
  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(COPY_WORDS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                   state, state_n;
  logic [IW-1:0]            idx, idx_n;
  logic [TW-1:0]            tcnt, tcnt_n;
  logic [ROM_ADDR_BITS-1:0] rom_addr_n;
  logic                     rom_ce_n;
  logic [31:0]              wb_adr_n, wb_dat_n;
  logic [3:0]               wb_sel_n;
  logic                     wb_we_n, wb_cyc_n, wb_stb_n;
  logic                     busy_n, done_n, error_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      tcnt     <= '0;
      rom_addr <= '0;
      rom_ce   <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      tcnt     <= tcnt_n;
      rom_addr <= rom_addr_n;
      rom_ce   <= rom_ce_n;
      wb_adr_o <= wb_adr_n;
      wb_dat_o <= wb_dat_n;
      wb_sel_o <= wb_sel_n;
      wb_we_o  <= wb_we_n;
      wb_cyc_o <= wb_cyc_n;
      wb_stb_o <= wb_stb_n;
      busy     <= busy_n;
      done     <= done_n;
      error    <= error_n;
    end
  end

  // Registered outputs for a state are loaded on the edge that enters it,
  // so rom_ce is high exactly during FETCH and the bus is up exactly during WRITE.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    tcnt_n     = tcnt;
    rom_addr_n = rom_addr;
    rom_ce_n   = 1'b0;
    wb_adr_n   = wb_adr_o;
    wb_dat_n   = wb_dat_o;
    wb_sel_n   = wb_sel_o;
    wb_we_n    = wb_we_o;
    wb_cyc_n   = wb_cyc_o;
    wb_stb_n   = wb_stb_o;
    busy_n     = busy;
    done_n     = done;
    error_n    = error;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_n     = 1'b0;
          error_n    = 1'b0;
          busy_n     = 1'b1;
          idx_n      = '0;
          rom_ce_n   = 1'b1;
          rom_addr_n = '0;
          state_n    = S_FETCH;
        end
      end

      S_FETCH: begin
        state_n = S_CAPTURE;
      end

      S_CAPTURE: begin
        wb_dat_n = rom_data;
        wb_adr_n = DEST_BASE + {{(30-IW){1'b0}}, idx, 2'b00};
        wb_cyc_n = 1'b1;
        wb_stb_n = 1'b1;
        wb_we_n  = 1'b1;
        wb_sel_n = 4'hF;
        tcnt_n   = '0;
        state_n  = S_WRITE;
      end

      S_WRITE: begin
        if (wb_ack_i) begin
          wb_cyc_n = 1'b0;
          wb_stb_n = 1'b0;
          wb_we_n  = 1'b0;
          wb_sel_n = 4'h0;
          if (idx == LAST_IDX) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            idx_n      = idx + 1'b1;
            rom_ce_n   = 1'b1;
            rom_addr_n = idx_n[ROM_ADDR_BITS-1:0];
            state_n    = S_FETCH;
          end
        end else if (ACK_TIMEOUT != 0) begin
          // An ack arriving on the limit cycle is taken by the branch above.
          if (tcnt == TO_LAST) begin
            wb_cyc_n = 1'b0;
            wb_stb_n = 1'b0;
            wb_we_n  = 1'b0;
            wb_sel_n = 4'h0;
            busy_n   = 1'b0;
            done_n   = 1'b1;
            error_n  = 1'b1;
            state_n  = S_DONE;
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rom_boot_copier.sv
// Bench for rom_boot_copier: a 4-word instance with a 5-cycle ack timeout and a full-ROM instance without timeout.
// Expected traffic and cycle counts come from a per-word model: WRITE lasts 'wait' cycles, or the timeout and then abort.
module tb_rom_boot_copier;

  localparam logic [31:0] BASE_A  = 32'h8000_0000;
  localparam logic [31:0] BASE_B  = 32'hFFFF_FC00;
  localparam int          WORDS_A = 4;
  localparam int          TO_A    = 5;
  localparam int          WORDS_B = 256;
  localparam int          STALL_B = 10;
  localparam int          STALL_W = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  // instance A signals
  logic        start_a, rom_ce_a, we_a, cyc_a, stb_a, ack_a, busy_a, done_a, error_a;
  logic [7:0]  rom_addr_a;
  logic [31:0] rom_data_a, adr_a, dat_a;
  logic [3:0]  sel_a;
  // instance B signals
  logic        start_b, rom_ce_b, we_b, cyc_b, stb_b, ack_b, busy_b, done_b, error_b;
  logic [7:0]  rom_addr_b;
  logic [31:0] rom_data_b, adr_b, dat_b;
  logic [3:0]  sel_b;

  rom_boot_copier #(.COPY_WORDS(WORDS_A), .DEST_BASE(BASE_A), .ACK_TIMEOUT(TO_A)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .rom_addr(rom_addr_a), .rom_ce(rom_ce_a), .rom_data(rom_data_a),
    .wb_adr_o(adr_a), .wb_dat_o(dat_a), .wb_sel_o(sel_a), .wb_we_o(we_a),
    .wb_cyc_o(cyc_a), .wb_stb_o(stb_a), .wb_ack_i(ack_a),
    .busy(busy_a), .done(done_a), .error(error_a));

  rom_boot_copier #(.COPY_WORDS(WORDS_B), .DEST_BASE(BASE_B), .ACK_TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .rom_addr(rom_addr_b), .rom_ce(rom_ce_b), .rom_data(rom_data_b),
    .wb_adr_o(adr_b), .wb_dat_o(dat_b), .wb_sel_o(sel_b), .wb_we_o(we_b),
    .wb_cyc_o(cyc_b), .wb_stb_o(stb_b), .wb_ack_i(ack_b),
    .busy(busy_b), .done(done_b), .error(error_b));

  // ROMs with registered read
  logic [31:0] rom_a [256];
  logic [31:0] rom_b [256];
  always @(posedge clk) if (rom_ce_a) rom_data_a <= rom_a[rom_addr_a];
  always @(posedge clk) if (rom_ce_b) rom_data_b <= rom_b[rom_addr_b];

  // Slaves: word i is acked in its waits[i]-th strobe cycle (waits > TO_A means never)
  int          waits_a [WORDS_A];
  int          wcnt_a = 0, wcnt_b = 0;
  logic        force_ack_a;
  logic [31:0] woff_a, woff_b;

  always_comb begin
    woff_a = (adr_a - BASE_A) >> 2;
    ack_a  = force_ack_a;
    if (cyc_a && stb_a && woff_a < WORDS_A && wcnt_a + 1 == waits_a[woff_a[1:0]]) ack_a = 1'b1;
  end
  always_comb begin
    woff_b = (adr_b - BASE_B) >> 2;
    ack_b  = cyc_b && stb_b && (woff_b != STALL_B || wcnt_b == STALL_W - 1);
  end
  always @(posedge clk) wcnt_a <= (cyc_a && stb_a && !ack_a) ? wcnt_a + 1 : 0;
  always @(posedge clk) wcnt_b <= (cyc_b && stb_b && !ack_b) ? wcnt_b + 1 : 0;

  // Monitors sample mid-cycle
  logic [31:0] log_adr_a[$], log_dat_a[$], log_adr_b[$], log_dat_b[$];
  int busy_cyc_a, ce_cyc_a, cyc_cyc_a, stab_bad_a, sel_bad_a, busy_cyc_b, sel_bad_b;
  logic [31:0] p_adr_a, p_dat_a;
  logic [3:0]  p_sel_a;
  logic        p_cyc_a = 1'b0, p_ack_a = 1'b0, p_we_a, p_stb_a;

  always @(negedge clk) begin
    if (busy_a) busy_cyc_a++;
    if (rom_ce_a) ce_cyc_a++;
    if (cyc_a) cyc_cyc_a++;
    if (cyc_a && p_cyc_a && !p_ack_a &&
        (adr_a !== p_adr_a || dat_a !== p_dat_a || sel_a !== p_sel_a || we_a !== p_we_a || stb_a !== p_stb_a))
      stab_bad_a++;
    if (cyc_a && stb_a && ack_a) begin
      log_adr_a.push_back(adr_a);
      log_dat_a.push_back(dat_a);
      if (sel_a !== 4'hF || we_a !== 1'b1) sel_bad_a++;
    end
    p_adr_a = adr_a; p_dat_a = dat_a; p_sel_a = sel_a; p_we_a = we_a;
    p_stb_a = stb_a; p_cyc_a = cyc_a; p_ack_a = ack_a;
  end

  always @(negedge clk) begin
    if (busy_b) busy_cyc_b++;
    if (cyc_b && stb_b && ack_b) begin
      log_adr_b.push_back(adr_b);
      log_dat_b.push_back(dat_b);
      if (sel_b !== 4'hF || we_b !== 1'b1) sel_bad_b++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: per-word outcome from the wait table
  task automatic model_a(output int nw, output int bc, output int cc, output int ce, output bit er);
    nw = 0; bc = 0; cc = 0; ce = 0; er = 1'b0;
    for (int i = 0; i < WORDS_A; i++) begin
      ce++;
      if (waits_a[i] <= TO_A) begin
        nw++; bc += 2 + waits_a[i]; cc += waits_a[i];
      end else begin
        bc += 2 + TO_A; cc += TO_A; er = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_a();
    log_adr_a.delete(); log_dat_a.delete();
    busy_cyc_a = 0; ce_cyc_a = 0; cyc_cyc_a = 0; stab_bad_a = 0; sel_bad_a = 0;
  endtask

  task automatic run_a(input string tag, input bit disturb);
    int nw, bc, cc, ce, t;
    bit er;
    model_a(nw, bc, cc, ce, er);
    @(posedge clk); #1;
    clear_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk);
    chk({tag, "_busy_up"}, busy_a, 1);
    chk({tag, "_done_err_clr"}, {done_a, error_a}, 0);
    if (disturb) begin
      // start held and a stray ack during FETCH; both must be ignored
      force_ack_a = 1'b1;
      @(negedge clk);
      force_ack_a = 1'b0;
    end
    start_a = 1'b0;
    t = 0;
    while (busy_a && t < 3000) begin @(negedge clk); t++; end
    chk({tag, "_terminates"}, t < 3000, 1);
    repeat (4) @(negedge clk);
    chk({tag, "_n_writes"}, log_adr_a.size(), nw);
    for (int i = 0; i < nw && i < log_adr_a.size(); i++) begin
      chk({tag, "_wr_adr"}, log_adr_a[i], BASE_A + 32'(4 * i));
      chk({tag, "_wr_dat"}, log_dat_a[i], rom_a[i]);
    end
    chk({tag, "_busy_cycles"}, busy_cyc_a, bc);
    chk({tag, "_ce_pulses"}, ce_cyc_a, ce);
    chk({tag, "_cyc_cycles"}, cyc_cyc_a, cc);
    chk({tag, "_bus_stable"}, stab_bad_a, 0);
    chk({tag, "_sel_we"}, sel_bad_a, 0);
    chk({tag, "_end_flags"}, {busy_a, done_a, error_a, cyc_a, stb_a, we_a}, {3'b010 | {2'b00, er}, 3'b000});
  endtask

  initial begin
    int t;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; force_ack_a = 1'b0;
    foreach (waits_a[i]) waits_a[i] = 1;
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = 32'h1000_0000 + 32'(i);
      rom_b[i] = $urandom;
    end
    repeat (3) @(negedge clk);
    chk("reset_ctrl_a", {rom_addr_a, rom_ce_a, sel_a, we_a, cyc_a, stb_a, busy_a, done_a, error_a}, 0);
    chk("reset_bus_a", adr_a | dat_a, 0);
    chk("reset_ctrl_b", {rom_addr_b, rom_ce_b, cyc_b, busy_b, done_b, error_b}, 0);
    reset = 1'b0;
    @(negedge clk);

    // zero-wait copy
    run_a("zero_wait", 1'b0);
    chk("zero_wait_busy12", busy_cyc_a, 12);

    // wait states, random ROM
    for (int i = 0; i < 256; i++) rom_a[i] = $urandom;
    foreach (waits_a[i]) waits_a[i] = 3;
    run_a("wait3", 1'b0);
    chk("wait3_busy20", busy_cyc_a, 20);

    // ack on the timeout cycle wins
    waits_a = '{1, 5, 2, 4};
    run_a("ack_at_limit", 1'b0);

    // timeout on word 1
    waits_a = '{1, 99, 1, 1};
    run_a("timeout", 1'b0);
    chk("timeout_cyc6", cyc_cyc_a, 6);

    // random wait profiles, some exceed the timeout
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) rom_a[i] = $urandom;
      foreach (waits_a[i]) waits_a[i] = $urandom_range(1, 6);
      run_a("random", 1'b0);
    end

    // reset during WRITE of word 2
    foreach (waits_a[i]) waits_a[i] = 3;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    t = 0;
    while (!(cyc_a && adr_a == BASE_A + 32'h8) && t < 200) begin @(negedge clk); t++; end
    chk("rst_reach_word2", t < 200, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_run", {cyc_a, stb_a, we_a, busy_a, done_a, error_a, rom_ce_a}, 0);
    reset = 1'b0;
    waits_a = '{1, 1, 1, 1};
    run_a("after_reset", 1'b0);

    // ignored inputs, then identical restart from DONE
    waits_a = '{2, 1, 3, 1};
    run_a("disturbed", 1'b1);
    run_a("restart", 1'b0);

    // full ROM, one long stall with timeout disabled
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    t = 0;
    while (busy_b && t < 5000) begin @(negedge clk); t++; end
    chk("full_terminates", t < 5000, 1);
    @(negedge clk);
    chk("full_n_writes", log_adr_b.size(), WORDS_B);
    t = 0;
    for (int i = 0; i < WORDS_B && i < log_adr_b.size(); i++)
      if (log_adr_b[i] !== BASE_B + 32'(4 * i) || log_dat_b[i] !== rom_b[i]) t++;
    chk("full_seq_errors", t, 0);
    if (log_adr_b.size() > 0) begin
      chk("full_last_adr", log_adr_b[log_adr_b.size() - 1], 32'hFFFF_FFFC);
      chk("full_last_dat", log_dat_b[log_dat_b.size() - 1], rom_b[255]);
    end
    chk("full_busy_cycles", busy_cyc_b, 3 * WORDS_B + STALL_W - 1);
    chk("full_sel_we", sel_bad_b, 0);
    chk("full_end_flags", {busy_b, done_b, error_b, cyc_b}, 4'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
